// File: rtl/march_elem_gen_if.sv
// Op command type and the controller-facing bundle of march_elem_gen.
// Ports: master = test controller side (drives i_*, observes o_*),
//        slave  = march_elem_gen side (observes i_*, drives o_*).

package march_elem_gen_pkg;
    // NOP is encoded as zero so the reset value of the op register is NOP.
    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } t_op_cmd;
endpackage

interface march_elem_gen_if #(
    parameter int ADDR_X  = 2,
    parameter int ADDR_Y  = 2,
    parameter int BG_DATA = 4
);
    import march_elem_gen_pkg::*;

    // Element request and its configuration (sampled on start only).
    logic               i_start;
    logic               i_pause;
    logic               i_dir_down;
    logic               i_x_fast;
    logic [1:0]         i_num_ops;
    logic [3:0]         i_op_wr;
    logic [3:0]         i_op_inv;
    logic [BG_DATA-1:0] i_bg_data;

    // Per-cycle memory command stream and status.
    logic [ADDR_X-1:0]  o_addr_x;
    logic [ADDR_Y-1:0]  o_addr_y;
    logic [BG_DATA-1:0] o_data;
    t_op_cmd            o_op_cmd;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_start, i_pause, i_dir_down, i_x_fast,
               i_num_ops, i_op_wr, i_op_inv, i_bg_data,
        input  o_addr_x, o_addr_y, o_data, o_op_cmd, o_busy, o_done
    );

    modport slave (
        input  i_start, i_pause, i_dir_down, i_x_fast,
               i_num_ops, i_op_wr, i_op_inv, i_bg_data,
        output o_addr_x, o_addr_y, o_data, o_op_cmd, o_busy, o_done
    );
endinterface

// File: rtl/march_elem_gen.sv
// Executes one march element over the full X/Y space: one op per cycle.
// Latency: first op one cycle after i_start; all outputs registered.
// Backpressure: i_pause inserts NOP cycles; the op sequence resumes unchanged.
// Ports: clk, rst (sync, active-high), bus (march_elem_gen_if.slave).

module march_elem_gen
    import march_elem_gen_pkg::*;
#(
    parameter int ADDR_X  = 2,
    parameter int ADDR_Y  = 2,
    parameter int BG_DATA = 4
) (
    input  logic              clk,
    input  logic              rst,
    march_elem_gen_if.slave   bus
);

    localparam logic [ADDR_X-1:0] X_MAX = {ADDR_X{1'b1}};
    localparam logic [ADDR_Y-1:0] Y_MAX = {ADDR_Y{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;

    // Latched element configuration.
    logic               dir_q, dir_d;
    logic               xfast_q, xfast_d;
    logic [1:0]         num_q, num_d;
    logic [3:0]         wr_q, wr_d;
    logic [3:0]         inv_q, inv_d;
    logic [BG_DATA-1:0] bg_q, bg_d;

    // Pointer to the next op still to be issued. It runs one op ahead of
    // the output registers, so a pause can show the upcoming address while
    // the op itself is withheld.
    logic [ADDR_X-1:0]  px_q, px_d;
    logic [ADDR_Y-1:0]  py_q, py_d;
    logic [1:0]         pk_q, pk_d;
    // Set once the final op of the element has been issued.
    logic               last_q, last_d;

    // Output registers.
    logic [ADDR_X-1:0]  ox_q, ox_d;
    logic [ADDR_Y-1:0]  oy_q, oy_d;
    logic [BG_DATA-1:0] odata_q, odata_d;
    t_op_cmd            op_q, op_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // ------------------------------------------------------------------
    // Op source: on the start cycle the op is built straight from the
    // inputs and the start address; afterwards from latched state.
    // ------------------------------------------------------------------
    logic               is_start;
    logic               c_dir, c_xfast;
    logic [1:0]         c_num;
    logic [3:0]         c_wr, c_inv;
    logic [BG_DATA-1:0] c_bg;
    logic [ADDR_X-1:0]  s_x, x_start, x_end, x_step;
    logic [ADDR_Y-1:0]  s_y, y_start, y_end, y_step;
    logic [1:0]         s_k;

    // Issue results and the pointer after this op.
    t_op_cmd            iss_cmd;
    logic [BG_DATA-1:0] iss_data;
    logic               k_last, x_at_end, y_at_end, is_final;
    logic [ADDR_X-1:0]  nx;
    logic [ADDR_Y-1:0]  ny;
    logic [1:0]         nk;

    always_comb begin
        is_start = (state_q == ST_IDLE) && bus.i_start;

        c_dir    = is_start ? bus.i_dir_down : dir_q;
        c_xfast  = is_start ? bus.i_x_fast   : xfast_q;
        c_num    = is_start ? bus.i_num_ops  : num_q;
        c_wr     = is_start ? bus.i_op_wr    : wr_q;
        c_inv    = is_start ? bus.i_op_inv   : inv_q;
        c_bg     = is_start ? bus.i_bg_data  : bg_q;

        // Ascending walks 0 -> max, descending max -> 0, on both axes.
        x_start  = c_dir ? X_MAX : '0;
        y_start  = c_dir ? Y_MAX : '0;
        x_end    = c_dir ? '0 : X_MAX;
        y_end    = c_dir ? '0 : Y_MAX;

        s_x      = is_start ? x_start : px_q;
        s_y      = is_start ? y_start : py_q;
        s_k      = is_start ? 2'd0    : pk_q;

        x_step   = c_dir ? (s_x - ADDR_X'(1)) : (s_x + ADDR_X'(1));
        y_step   = c_dir ? (s_y - ADDR_Y'(1)) : (s_y + ADDR_Y'(1));
    end

    always_comb begin
        iss_cmd  = c_wr[s_k] ? OP_WRITE : OP_READ;
        iss_data = c_inv[s_k] ? ~c_bg : c_bg;

        k_last   = (s_k == c_num);
        x_at_end = (s_x == x_end);
        y_at_end = (s_y == y_end);
        is_final = k_last && x_at_end && y_at_end;

        nx = s_x;
        ny = s_y;
        nk = s_k;
        if (is_final) begin
            // End of element: pointer parks, no wrap past the last address.
            nk = s_k;
        end else if (!k_last) begin
            nk = s_k + 2'd1;
        end else begin
            nk = 2'd0;
            if (c_xfast) begin
                if (x_at_end) begin
                    nx = x_start;
                    ny = y_step;
                end else begin
                    nx = x_step;
                end
            end else begin
                if (y_at_end) begin
                    ny = y_start;
                    nx = x_step;
                end else begin
                    ny = y_step;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        xfast_d = xfast_q;
        num_d   = num_q;
        wr_d    = wr_q;
        inv_d   = inv_q;
        bg_d    = bg_q;
        px_d    = px_q;
        py_d    = py_q;
        pk_d    = pk_q;
        last_d  = last_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        odata_d = odata_q;
        op_d    = OP_NOP;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    dir_d   = bus.i_dir_down;
                    xfast_d = bus.i_x_fast;
                    num_d   = bus.i_num_ops;
                    wr_d    = bus.i_op_wr;
                    inv_d   = bus.i_op_inv;
                    bg_d    = bus.i_bg_data;
                    // Op 0 goes out with the start, pointer moves to op 1.
                    ox_d    = s_x;
                    oy_d    = s_y;
                    odata_d = iss_data;
                    op_d    = iss_cmd;
                    px_d    = nx;
                    py_d    = ny;
                    pk_d    = nk;
                    last_d  = is_final;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (last_q) begin
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (bus.i_pause) begin
                    // Withhold the op; show where the sequence will resume.
                    ox_d = px_q;
                    oy_d = py_q;
                end else begin
                    ox_d    = s_x;
                    oy_d    = s_y;
                    odata_d = iss_data;
                    op_d    = iss_cmd;
                    px_d    = nx;
                    py_d    = ny;
                    pk_d    = nk;
                    last_d  = is_final;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            xfast_q <= 1'b0;
            num_q   <= 2'd0;
            wr_q    <= 4'd0;
            inv_q   <= 4'd0;
            bg_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            pk_q    <= 2'd0;
            last_q  <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            odata_q <= '0;
            op_q    <= OP_NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            xfast_q <= xfast_d;
            num_q   <= num_d;
            wr_q    <= wr_d;
            inv_q   <= inv_d;
            bg_q    <= bg_d;
            px_q    <= px_d;
            py_q    <= py_d;
            pk_q    <= pk_d;
            last_q  <= last_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            odata_q <= odata_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_addr_x = ox_q;
    assign bus.o_addr_y = oy_q;
    assign bus.o_data   = odata_q;
    assign bus.o_op_cmd = op_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_done   = done_q;

endmodule
